// File: rtl/reg_file_pkg.sv
// Shared definitions for the architectural register file and its read ports.
package reg_file_pkg;

  localparam int unsigned REG_NUM      = 32;
  localparam int unsigned REG_POS_W    = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ROB_ID_W     = 5;
  localparam int unsigned ROB_SIZE     = (1 << ROB_ID_W) - 1;

  typedef logic [REG_POS_W-1:0] reg_pos_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_ID_W-1:0]  rob_id_t;

  localparam reg_pos_t ZERO_REG    = '0;
  localparam rob_id_t  INVALID_ROB = '0;
  localparam data_t    NULL        = '0;

  // Per-register tag update selected for the coming clock edge.
  typedef enum logic [1:0] {
    TAG_HOLD,
    TAG_CLEAR,
    TAG_RENAME
  } tag_op_e;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational source-operand lookup with commit bypass.
module reg_read_port #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ROB_ID_WIDTH = 5
) (
  input  logic [4:0]              rs,
  input  logic [ROB_ID_WIDTH-1:0] tag_at_rs,
  input  logic [DATA_WIDTH-1:0]   data_at_rs,
  input  logic                    commit_sign,
  input  logic [ROB_ID_WIDTH-1:0] Q_from_rob,
  input  logic [DATA_WIDTH-1:0]   V_from_rob,
  output logic [ROB_ID_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0]   v
);
  import reg_file_pkg::*;

  logic bypass;

  // x0 reads as final zero; a committing producer is forwarded before it lands in storage.
  always_comb begin
    bypass = (tag_at_rs != '0) && commit_sign && (Q_from_rob == tag_at_rs);
    q      = '0;
    v      = '0;
    if (rs == ZERO_REG) begin
      q = '0;
      v = '0;
    end else if (bypass) begin
      q = '0;
      v = V_from_rob;
    end else begin
      q = tag_at_rs;
      v = data_at_rs;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 32 values plus one in-flight producer tag each.
module reg_file #(
  parameter int unsigned REG_NUM      = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ROB_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [4:0]              rs1_from_cmd,
  input  logic [4:0]              rs2_from_cmd,
  output logic [ROB_ID_WIDTH-1:0] Q1_to_cmd,
  output logic [ROB_ID_WIDTH-1:0] Q2_to_cmd,
  output logic [DATA_WIDTH-1:0]   V1_to_cmd,
  output logic [DATA_WIDTH-1:0]   V2_to_cmd,
  input  logic                    rename_sign_from_cmd,
  input  logic [4:0]              rd_from_cmd,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_from_cmd,
  input  logic                    commit_sign,
  input  logic [4:0]              rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0] Q_from_rob,
  input  logic [DATA_WIDTH-1:0]   V_from_rob,
  input  logic                    rollback_sign
);
  import reg_file_pkg::*;

  typedef logic [DATA_WIDTH-1:0]   word_t;
  typedef logic [ROB_ID_WIDTH-1:0] tag_t;

  word_t   data_q [REG_NUM];
  word_t   data_d [REG_NUM];
  tag_t    tag_q  [REG_NUM];
  tag_t    tag_d  [REG_NUM];
  tag_op_e tag_op [REG_NUM];

  logic commit_en;
  logic rename_en;

  // Decode this cycle's tag action per register; rename is decided last so it
  // overrides a commit clear on the same rd, and rollback suppresses rename.
  always_comb begin
    commit_en = rdy && commit_sign && (rd_from_rob != ZERO_REG);
    rename_en = rdy && rename_sign_from_cmd && (rd_from_cmd != ZERO_REG) && !rollback_sign;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      tag_op[i] = TAG_HOLD;
    end
    if (commit_en && (tag_q[rd_from_rob] == Q_from_rob)) begin
      tag_op[rd_from_rob] = TAG_CLEAR;
    end
    if (rdy && rollback_sign) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        tag_op[i] = TAG_CLEAR;
      end
    end
    if (rename_en) begin
      tag_op[rd_from_cmd] = TAG_RENAME;
    end
  end

  // Next-state storage: commit writes data even under rollback; x0 stays zero.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (commit_en) begin
      data_d[rd_from_rob] = V_from_rob;
    end
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      case (tag_op[i])
        TAG_CLEAR:  tag_d[i] = '0;
        TAG_RENAME: tag_d[i] = rob_id_from_cmd;
        default:    tag_d[i] = tag_q[i];
      endcase
    end
    data_d[0] = '0;
    tag_d[0]  = '0;
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  reg_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ROB_ID_WIDTH(ROB_ID_WIDTH)
  ) u_rd1 (
    .rs         (rs1_from_cmd),
    .tag_at_rs  (tag_q[rs1_from_cmd]),
    .data_at_rs (data_q[rs1_from_cmd]),
    .commit_sign(commit_sign),
    .Q_from_rob (Q_from_rob),
    .V_from_rob (V_from_rob),
    .q          (Q1_to_cmd),
    .v          (V1_to_cmd)
  );

  reg_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ROB_ID_WIDTH(ROB_ID_WIDTH)
  ) u_rd2 (
    .rs         (rs2_from_cmd),
    .tag_at_rs  (tag_q[rs2_from_cmd]),
    .data_at_rs (data_q[rs2_from_cmd]),
    .commit_sign(commit_sign),
    .Q_from_rob (Q_from_rob),
    .V_from_rob (V_from_rob),
    .q          (Q2_to_cmd),
    .v          (V2_to_cmd)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected lookups, monitor checks them.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  rs1_from_cmd, rs2_from_cmd;
  logic [4:0]  Q1_to_cmd, Q2_to_cmd;
  logic [31:0] V1_to_cmd, V2_to_cmd;
  logic        rename_sign_from_cmd;
  logic [4:0]  rd_from_cmd, rob_id_from_cmd;
  logic        commit_sign;
  logic [4:0]  rd_from_rob, Q_from_rob;
  logic [31:0] V_from_rob;
  logic        rollback_sign;

  typedef struct {
    string       name;
    logic [4:0]  q1;
    logic [31:0] v1;
    logic [4:0]  q2;
    logic [31:0] v2;
  } exp_t;

  exp_t exp_q[$];
  logic chk;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file #(
    .REG_NUM     (32),
    .DATA_WIDTH  (32),
    .ROB_ID_WIDTH(5)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .rs1_from_cmd        (rs1_from_cmd),
    .rs2_from_cmd        (rs2_from_cmd),
    .Q1_to_cmd           (Q1_to_cmd),
    .Q2_to_cmd           (Q2_to_cmd),
    .V1_to_cmd           (V1_to_cmd),
    .V2_to_cmd           (V2_to_cmd),
    .rename_sign_from_cmd(rename_sign_from_cmd),
    .rd_from_cmd         (rd_from_cmd),
    .rob_id_from_cmd     (rob_id_from_cmd),
    .commit_sign         (commit_sign),
    .rd_from_rob         (rd_from_rob),
    .Q_from_rob          (Q_from_rob),
    .V_from_rob          (V_from_rob),
    .rollback_sign       (rollback_sign)
  );

  // Monitor: on the falling edge, compare the presented lookup with the oldest expectation.
  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: lookup presented with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (Q1_to_cmd !== e.q1) begin
          errors++;
          $display("FAIL %s Q1: got %0d expected %0d", e.name, Q1_to_cmd, e.q1);
        end
        if (V1_to_cmd !== e.v1) begin
          errors++;
          $display("FAIL %s V1: got %h expected %h", e.name, V1_to_cmd, e.v1);
        end
        if (Q2_to_cmd !== e.q2) begin
          errors++;
          $display("FAIL %s Q2: got %0d expected %0d", e.name, Q2_to_cmd, e.q2);
        end
        if (V2_to_cmd !== e.v2) begin
          errors++;
          $display("FAIL %s V2: got %h expected %h", e.name, V2_to_cmd, e.v2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk                  = 1'b0;
    commit_sign          = 1'b0;
    rename_sign_from_cmd = 1'b0;
    rollback_sign        = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] q1, input logic [31:0] v1,
                           input logic [4:0] q2, input logic [31:0] v2);
    exp_t e;
    e.name = name; e.q1 = q1; e.v1 = v1; e.q2 = q2; e.v2 = v2;
    rs1_from_cmd = r1;
    rs2_from_cmd = r2;
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    rename_sign_from_cmd = 1'b1;
    rd_from_cmd          = rd;
    rob_id_from_cmd      = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] v);
    commit_sign = 1'b1;
    rd_from_rob = rd;
    Q_from_rob  = id;
    V_from_rob  = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; chk = 1'b0;
    rs1_from_cmd = '0; rs2_from_cmd = '0;
    rename_sign_from_cmd = 1'b0; rd_from_cmd = '0; rob_id_from_cmd = '0;
    commit_sign = 1'b0; rd_from_rob = '0; Q_from_rob = '0; V_from_rob = '0;
    rollback_sign = 1'b0;
    step(); step();
    rst = 1'b0;

    expect_rd("reset", 5'd5, 5'd31, 5'd0, 32'h0, 5'd0, 32'h0);
    step();

    // Rename then commit
    rename(5'd3, 5'd4);
    expect_rd("rename_same_cycle", 5'd3, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    expect_rd("rename_visible", 5'd3, 5'd0, 5'd4, 32'h0, 5'd0, 32'h0);
    step();
    commit(5'd3, 5'd4, 32'hDEADBEEF);
    expect_rd("commit_bypass", 5'd3, 5'd3, 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    step();
    expect_rd("commit_stored", 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
    step();

    // Stale commit keeps the younger tag
    rename(5'd7, 5'd2);
    step();
    rename(5'd7, 5'd6);
    step();
    commit(5'd7, 5'd2, 32'h11);
    expect_rd("stale_no_bypass", 5'd7, 5'd0, 5'd6, 32'h0, 5'd0, 32'h0);
    step();
    expect_rd("stale_tag_kept", 5'd7, 5'd0, 5'd6, 32'h11, 5'd0, 32'h0);
    step();

    // Same-cycle commit and rename on one rd
    rename(5'd9, 5'd3);
    step();
    commit(5'd9, 5'd3, 32'h55);
    rename(5'd9, 5'd8);
    expect_rd("commit_rename_bypass", 5'd9, 5'd0, 5'd0, 32'h55, 5'd0, 32'h0);
    step();
    expect_rd("rename_beats_clear", 5'd9, 5'd0, 5'd8, 32'h55, 5'd0, 32'h0);
    step();

    // Rollback with concurrent commit and rename
    commit(5'd2, 5'd12, 32'h22);
    step();
    rename(5'd1, 5'd1);
    step();
    rename(5'd2, 5'd2);
    step();
    rename(5'd10, 5'd10);
    step();
    rollback_sign = 1'b1;
    commit(5'd1, 5'd1, 32'h40);
    rename(5'd2, 5'd5);
    expect_rd("rollback_same_cycle", 5'd1, 5'd2, 5'd0, 32'h40, 5'd2, 32'h22);
    step();
    expect_rd("rollback_x1_x2", 5'd1, 5'd2, 5'd0, 32'h40, 5'd0, 32'h22);
    step();
    expect_rd("rollback_x10_x7", 5'd10, 5'd7, 5'd0, 32'h0, 5'd0, 32'h11);
    step();
    expect_rd("rollback_x9_x3", 5'd9, 5'd3, 5'd0, 32'h55, 5'd0, 32'hDEADBEEF);
    step();

    // x0 is immutable
    rename(5'd0, 5'd7);
    commit(5'd0, 5'd0, 32'hFFFF);
    expect_rd("x0_same_cycle", 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    expect_rd("x0_after", 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
    step();

    // rdy low holds all state
    rename(5'd4, 5'd9);
    step();
    rename(5'd6, 5'd11);
    step();
    rdy = 1'b0;
    commit(5'd4, 5'd9, 32'h99);
    expect_rd("rdy_low_bypass", 5'd4, 5'd6, 5'd0, 32'h99, 5'd11, 32'h0);
    step();
    rollback_sign = 1'b1;
    rename(5'd5, 5'd3);
    expect_rd("rdy_low_unchanged", 5'd4, 5'd0, 5'd9, 32'h0, 5'd0, 32'h0);
    step();
    rdy = 1'b1;
    commit(5'd4, 5'd9, 32'h99);
    expect_rd("rdy_high_commit", 5'd4, 5'd6, 5'd0, 32'h99, 5'd11, 32'h0);
    step();
    expect_rd("rdy_commit_applied", 5'd4, 5'd5, 5'd0, 32'h99, 5'd0, 32'h0);
    step();

    // Reset overrides concurrent activity
    rst = 1'b1;
    commit(5'd3, 5'd0, 32'h77);
    rename(5'd9, 5'd1);
    step();
    rst = 1'b0;
    expect_rd("reset_clears", 5'd3, 5'd9, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    expect_rd("reset_clears_x6", 5'd6, 5'd7, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
